// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for one shared 32-bit memory port.
// One transaction in flight, req/ack handshake, optional access timeout.
module mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [1:0]      req_i,
    input  logic [2*AW-1:0] addr_i,
    input  logic [1:0]      we_i,
    input  logic [63:0]     wdata_i,
    input  logic [7:0]      wstrb_i,
    output logic [1:0]      gnt_o,
    output logic [1:0]      rsp_o,
    output logic [31:0]     rdata_o,
    output logic            err_o,
    output logic            mem_req_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic            mem_we_o,
    output logic [31:0]     mem_wdata_o,
    output logic [3:0]      mem_wstrb_o,
    input  logic            mem_ack_i,
    input  logic [31:0]     mem_rdata_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int unsigned CW =
        (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic          TO_EN    = (TIMEOUT != 0);

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rsp_q, rsp_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          mreq_q, mreq_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic          mwe_q, mwe_d;
    logic [31:0]   mwdata_q, mwdata_d;
    logic [3:0]    mwstrb_q, mwstrb_d;

    logic          win;
    logic [AW-1:0] sel_addr;
    logic          sel_we;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_wstrb;
    logic [1:0]    owner_vec;
    logic          timed_out;

    // Winner: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        win = 1'b0;
        unique case (req_i)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_q;
            default: win = 1'b0;
        endcase
    end

    // Route the winning requester's fields toward the memory latches.
    always_comb begin
        sel_addr  = addr_i[0 +: AW];
        sel_we    = we_i[0];
        sel_wdata = wdata_i[0 +: 32];
        sel_wstrb = wstrb_i[0 +: 4];
        if (win) begin
            sel_addr  = addr_i[AW +: AW];
            sel_we    = we_i[1];
            sel_wdata = wdata_i[32 +: 32];
            sel_wstrb = wstrb_i[4 +: 4];
        end
    end

    assign owner_vec = last_q ? 2'b10 : 2'b01;
    assign timed_out = TO_EN && (cnt_q == CNT_LAST);

    // Next-state logic for the IDLE -> ACCESS -> RESP sequence.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        gnt_d    = 2'b00;
        rsp_d    = 2'b00;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        mreq_d   = mreq_q;
        maddr_d  = maddr_q;
        mwe_d    = mwe_q;
        mwdata_d = mwdata_q;
        mwstrb_d = mwstrb_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    maddr_d  = sel_addr;
                    mwe_d    = sel_we;
                    mwdata_d = sel_wdata;
                    mwstrb_d = sel_we ? sel_wstrb : 4'b0000;
                    gnt_d    = win ? 2'b10 : 2'b01;
                    mreq_d   = 1'b1;
                    last_d   = win;
                    cnt_d    = '0;
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ack_i) begin
                    rdata_d = mwe_q ? 32'h0 : mem_rdata_i;
                    err_d   = 1'b0;
                    rsp_d   = owner_vec;
                    mreq_d  = 1'b0;
                    state_d = S_RESP;
                end else if (timed_out) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    rsp_d   = owner_vec;
                    mreq_d  = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                mreq_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            gnt_q    <= 2'b00;
            rsp_q    <= 2'b00;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
            mreq_q   <= 1'b0;
            maddr_q  <= '0;
            mwe_q    <= 1'b0;
            mwdata_q <= 32'h0;
            mwstrb_q <= 4'h0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            rsp_q    <= rsp_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            mreq_q   <= mreq_d;
            maddr_q  <= maddr_d;
            mwe_q    <= mwe_d;
            mwdata_q <= mwdata_d;
            mwstrb_q <= mwstrb_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rsp_o       = rsp_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = mreq_q;
    assign mem_addr_o  = maddr_q;
    assign mem_we_o    = mwe_q;
    assign mem_wdata_o = mwdata_q;
    assign mem_wstrb_o = mwstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed requests, scoreboard queues
// for grants/responses, monitor compares on every falling edge.
module tb_mem_arbiter;

    localparam int AW = 32;

    typedef struct {
        logic [1:0]  rsp;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req;
    logic [2*AW-1:0] addr;
    logic [1:0]      we;
    logic [63:0]     wdata;
    logic [7:0]      wstrb;
    logic [1:0]      gnt_o;
    logic [1:0]      rsp_o;
    logic [31:0]     rdata_o;
    logic            err_o;
    logic            mem_req_o;
    logic [AW-1:0]   mem_addr_o;
    logic            mem_we_o;
    logic [31:0]     mem_wdata_o;
    logic [3:0]      mem_wstrb_o;
    logic            model_ack = 1'b0;
    logic            man_ack;
    logic            mem_ack;
    logic [31:0]     mem_data;

    int   ack_dly;
    int   mcnt = 0;
    logic prev_req = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t       rq[$];
    logic [1:0] gq[$];
    int         gcyc[$];

    assign mem_ack = model_ack | man_ack;

    mem_arbiter #(.AW(AW), .TIMEOUT(4)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_i(req),
        .addr_i(addr),
        .we_i(we),
        .wdata_i(wdata),
        .wstrb_i(wstrb),
        .gnt_o(gnt_o),
        .rsp_o(rsp_o),
        .rdata_o(rdata_o),
        .err_o(err_o),
        .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o),
        .mem_ack_i(mem_ack),
        .mem_rdata_i(mem_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Memory model: ack arrives ack_dly cycles after mem_req_o rises.
    always @(posedge clk) begin
        #1;
        if (mem_req_o) mcnt = prev_req ? mcnt + 1 : 0;
        prev_req  = mem_req_o;
        model_ack = mem_req_o && (ack_dly != 0) && (mcnt == ack_dly);
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever a grant or response appears.
    always @(negedge clk) begin
        if (|gnt_o) begin
            gcyc.push_back(cyc);
            if (gq.size() == 0) begin
                chk("unexpected_gnt", {30'b0, gnt_o}, 32'h0);
            end else begin
                chk("gnt", {30'b0, gnt_o}, {30'b0, gq.pop_front()});
            end
        end
        if (|rsp_o) begin
            if (rq.size() == 0) begin
                chk("unexpected_rsp", {30'b0, rsp_o}, 32'h0);
            end else begin
                exp_t e;
                e = rq.pop_front();
                chk("rsp", {30'b0, rsp_o}, {30'b0, e.rsp});
                chk("rdata", rdata_o, e.data);
                chk("err", {31'b0, err_o}, {31'b0, e.err});
            end
        end
        if (err_o && !(|rsp_o))
            chk("err_without_rsp", 32'h1, 32'h0);
    end

    task automatic issue(input int k, input logic [31:0] a,
                         input logic w, input logic [31:0] d,
                         input logic [3:0] s);
        bit got;
        got = 1'b0;
        @(negedge clk);
        addr[k*AW +: AW] = a;
        we[k]            = w;
        wdata[k*32 +: 32] = d;
        wstrb[k*4 +: 4]  = s;
        req[k]           = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt_o[k]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("gnt_timeout", 32'h0, 32'h1);
        end else begin
            chk("mem_req", {31'b0, mem_req_o}, 32'h1);
            chk("mem_addr", mem_addr_o, a);
            chk("mem_we", {31'b0, mem_we_o}, {31'b0, w});
            chk("mem_wstrb", {28'b0, mem_wstrb_o},
                {28'b0, (w ? s : 4'b0)});
            if (w) chk("mem_wdata", mem_wdata_o, d);
        end
        req[k] = 1'b0;
    endtask

    task automatic wait_rsp();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("rsp_timeout", 32'h0, 32'h1);
        repeat (2) @(negedge clk);
    endtask

    function automatic exp_t mk(input logic [1:0] r,
                                input logic [31:0] d,
                                input logic e);
        exp_t x;
        x.rsp  = r;
        x.data = d;
        x.err  = e;
        return x;
    endfunction

    initial begin
        int n;
        bit done;
        rst      = 1'b1;
        req      = 2'b00;
        addr     = '0;
        we       = 2'b00;
        wdata    = '0;
        wstrb    = '0;
        man_ack  = 1'b0;
        ack_dly  = 0;
        mem_data = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_gnt", {30'b0, gnt_o}, 32'h0);
        chk("rst_rsp", {30'b0, rsp_o}, 32'h0);
        chk("rst_err", {31'b0, err_o}, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we_o}, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        chk("rst_mem_wstrb", {28'b0, mem_wstrb_o}, 32'h0);
        rst = 1'b0;

        // Read by requester 0, ack three cycles after mem_req_o.
        ack_dly  = 3;
        mem_data = 32'hDEADBEEF;
        gq.push_back(2'b01);
        rq.push_back(mk(2'b01, 32'hDEADBEEF, 1'b0));
        issue(0, 32'h100, 1'b0, 32'hFFFFFFFF, 4'hF);
        wait_rsp();
        chk("rdata_hold", rdata_o, 32'hDEADBEEF);
        chk("rsp_cleared", {30'b0, rsp_o}, 32'h0);

        // Write by requester 1: read data must come back as zero.
        ack_dly  = 2;
        mem_data = 32'h55555555;
        gq.push_back(2'b10);
        rq.push_back(mk(2'b10, 32'h0, 1'b0));
        issue(1, 32'h2000, 1'b1, 32'h000000AB, 4'b0001);
        wait_rsp();

        // Memory never acks: timeout after exactly four ACCESS cycles.
        ack_dly  = 0;
        mem_data = 32'h77777777;
        gq.push_back(2'b01);
        rq.push_back(mk(2'b01, 32'h0, 1'b1));
        issue(0, 32'h300, 1'b0, 32'h0, 4'h0);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!mem_req_o) break;
            n++;
        end
        chk("timeout_req_cycles", n, 32'd4);
        wait_rsp();

        // Ack in the last allowed cycle beats the timeout.
        ack_dly  = 3;
        mem_data = 32'h12345678;
        gq.push_back(2'b01);
        rq.push_back(mk(2'b01, 32'h12345678, 1'b0));
        issue(0, 32'h304, 1'b0, 32'h0, 4'h0);
        wait_rsp();

        // Reset mid-access: no response, late ack ignored.
        ack_dly = 0;
        gq.push_back(2'b01);
        issue(0, 32'h400, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_mem_req", {31'b0, mem_req_o}, 32'h0);
        man_ack = 1'b1;
        repeat (2) @(negedge clk);
        chk("late_ack_mem_req", {31'b0, mem_req_o}, 32'h0);
        man_ack = 1'b0;
        ack_dly  = 2;
        mem_data = 32'h0BADF00D;
        gq.push_back(2'b10);
        rq.push_back(mk(2'b10, 32'h0BADF00D, 1'b0));
        issue(1, 32'h500, 1'b0, 32'h0, 4'h0);
        wait_rsp();

        // Both request continuously: alternate from requester 0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ack_dly  = 1;
        mem_data = 32'hCAFE0000;
        gcyc.delete();
        gq.push_back(2'b01);
        gq.push_back(2'b10);
        gq.push_back(2'b01);
        gq.push_back(2'b10);
        rq.push_back(mk(2'b01, 32'hCAFE0000, 1'b0));
        rq.push_back(mk(2'b10, 32'hCAFE0000, 1'b0));
        rq.push_back(mk(2'b01, 32'hCAFE0000, 1'b0));
        rq.push_back(mk(2'b10, 32'hCAFE0000, 1'b0));
        addr = {32'h8000, 32'h4000};
        we   = 2'b00;
        req  = 2'b11;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (gcyc.size() >= 4) begin
                done = 1'b1;
                break;
            end
        end
        req = 2'b00;
        if (!done) chk("rr_gnt_timeout", 32'h0, 32'h1);
        wait_rsp();
        if (gcyc.size() >= 4) begin
            for (int i = 0; i < 3; i++)
                chk("rr_spacing", gcyc[i+1] - gcyc[i], 32'd4);
        end
        chk("gq_drained", gq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
